// File: rtl/wired_cdb_slot_sched_if.sv
// Issue-side request bundle and CDB slot-table view for the writeback slot scheduler.
// REQ_CNT and MAX_LAT must match the parameters of the scheduler that uses this interface.
interface wired_cdb_slot_sched_if #(
   parameter int unsigned REQ_CNT = 4,
   parameter int unsigned MAX_LAT = 4
);
   localparam int unsigned LW = $clog2(MAX_LAT + 1);
   localparam int unsigned OW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

   logic                            flush_i;
   logic [REQ_CNT-1:0]              req_valid_i;
   logic [REQ_CNT-1:0][LW-1:0]      req_lat_i;
   logic [REQ_CNT-1:0]              req_bank_i;
   logic [1:0]                      ext_block_i;
   logic [REQ_CNT-1:0]              req_grant_o;
   logic [1:0]                      slot_valid_o;
   logic [1:0][OW-1:0]              slot_owner_o;
   logic [1:0][MAX_LAT-1:0]         busy_map_o;

   modport master (
      output flush_i, req_valid_i, req_lat_i, req_bank_i, ext_block_i,
      input  req_grant_o, slot_valid_o, slot_owner_o, busy_map_o
   );

   modport slave (
      input  flush_i, req_valid_i, req_lat_i, req_bank_i, ext_block_i,
      output req_grant_o, slot_valid_o, slot_owner_o, busy_map_o
   );
endinterface

// File: rtl/wired_cdb_slot_sched.sv
// Writeback-slot scheduler for the 2-bank CDB: fixed-latency ports reserve bank slot t+L at issue,
// with per-(bank,L) fixed-priority arbitration and an age-based anti-starvation boost.
module wired_cdb_slot_sched #(
   parameter int unsigned REQ_CNT   = 4,
   parameter int unsigned MAX_LAT   = 4,
   parameter int unsigned STARVE_TH = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   wired_cdb_slot_sched_if.slave bus
);
   localparam int unsigned LW = $clog2(MAX_LAT + 1);
   localparam int unsigned OW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
   localparam int unsigned AW = $clog2(STARVE_TH + 1);
   localparam logic [AW-1:0] AgeMax = AW'(STARVE_TH);

   logic [1:0][MAX_LAT-1:0]         occ_q, occ_d;
   logic [1:0][MAX_LAT-1:0][OW-1:0] own_q, own_d;
   logic [REQ_CNT-1:0][AW-1:0]      age_q, age_d;
   logic [REQ_CNT-1:0]              legal, row_busy, avail, boosted, grant;
   logic                            grant_clash, grant_bad;

   // Row L holds slot t+L; L==MAX_LAT lies beyond the table and is therefore always free.
   always_comb begin
      legal    = '0;
      row_busy = '0;
      avail    = '0;
      boosted  = '0;
      for (int i = 0; i < REQ_CNT; i++) begin
         legal[i] = (bus.req_lat_i[i] != '0) && (bus.req_lat_i[i] <= LW'(MAX_LAT));
         for (int k = 1; k < MAX_LAT; k++) begin
            if (bus.req_lat_i[i] == LW'(k)) row_busy[i] = occ_q[bus.req_bank_i[i]][k];
         end
         avail[i] = bus.req_valid_i[i] && legal[i] && !row_busy[i] &&
                    !((bus.req_lat_i[i] == LW'(1)) && bus.ext_block_i[bus.req_bank_i[i]]);
         boosted[i] = (age_q[i] == AgeMax);
      end
   end

   // A requester loses to any same-(bank,L) rival that is boosted when it is not,
   // or that has equal boost status and a lower index.
   always_comb begin
      grant = '0;
      for (int i = 0; i < REQ_CNT; i++) begin
         grant[i] = avail[i] && !bus.flush_i;
         for (int j = 0; j < REQ_CNT; j++) begin
            if ((j != i) && avail[j] &&
                (bus.req_bank_i[j] == bus.req_bank_i[i]) &&
                (bus.req_lat_i[j] == bus.req_lat_i[i]) &&
                ((boosted[j] && !boosted[i]) || ((boosted[j] == boosted[i]) && (j < i)))) begin
               grant[i] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      occ_d = '0;
      own_d = '0;
      age_d = age_q;
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < MAX_LAT - 1; k++) begin
            occ_d[b][k] = occ_q[b][k+1];
            own_d[b][k] = own_q[b][k+1];
         end
      end
      for (int i = 0; i < REQ_CNT; i++) begin
         for (int k = 0; k < MAX_LAT; k++) begin
            if (grant[i] && (bus.req_lat_i[i] == LW'(k + 1))) begin
               occ_d[bus.req_bank_i[i]][k] = 1'b1;
               own_d[bus.req_bank_i[i]][k] = OW'(i);
            end
         end
         if (bus.flush_i || !bus.req_valid_i[i] || grant[i]) begin
            age_d[i] = '0;
         end else if (age_q[i] != AgeMax) begin
            age_d[i] = age_q[i] + 1'b1;
         end
      end
      if (bus.flush_i) begin
         occ_d = '0;
         own_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= '0;
         own_q <= '0;
         age_q <= '0;
      end else begin
         occ_q <= occ_d;
         own_q <= own_d;
         age_q <= age_d;
      end
   end

   assign bus.req_grant_o  = grant;
   assign bus.slot_valid_o = {occ_q[1][0], occ_q[0][0]};
   assign bus.slot_owner_o = {own_q[1][0], own_q[0][0]};
   assign bus.busy_map_o   = occ_q;

   always_comb begin
      grant_clash = 1'b0;
      grant_bad   = 1'b0;
      for (int i = 0; i < REQ_CNT; i++) begin
         grant_bad = grant_bad | (grant[i] && !legal[i]);
         for (int j = i + 1; j < REQ_CNT; j++) begin
            grant_clash = grant_clash | (grant[i] && grant[j] &&
                                         (bus.req_bank_i[i] == bus.req_bank_i[j]) &&
                                         (bus.req_lat_i[i] == bus.req_lat_i[j]));
         end
      end
   end

   // Two grants on one (bank,L) would give one slot two owners.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!grant_clash);
         assert (!grant_bad);
      end
   end
endmodule

// File: tb/tb_wired_cdb_slot_sched.sv
// Bench for wired_cdb_slot_sched: directed scenarios plus randomized traffic against a model that
// tracks reservations by absolute cycle number.
module tb_wired_cdb_slot_sched;
   localparam int unsigned REQ_CNT   = 4;
   localparam int unsigned MAX_LAT   = 4;
   localparam int unsigned STARVE_TH = 8;
   localparam int unsigned LW        = $clog2(MAX_LAT + 1);
   localparam int unsigned OW        = $clog2(REQ_CNT);

   logic clk = 1'b0;
   logic rst_n;

   wired_cdb_slot_sched_if #(.REQ_CNT(REQ_CNT), .MAX_LAT(MAX_LAT)) bus ();

   wired_cdb_slot_sched #(
      .REQ_CNT  (REQ_CNT),
      .MAX_LAT  (MAX_LAT),
      .STARVE_TH(STARVE_TH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Model: reservations keyed by absolute cycle number, value = owner index.
   int res0 [int];
   int res1 [int];
   int cyc = 0;
   int age_m [REQ_CNT];
   logic [REQ_CNT-1:0] exp_grant;

   logic [REQ_CNT-1:0]      obs_grant;
   logic [1:0][MAX_LAT-1:0] obs_busy;
   logic [1:0]              obs_valid;
   logic [1:0][OW-1:0]      obs_owner;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit taken(input int b, input int s);
      if (b == 0) return res0.exists(s);
      return res1.exists(s);
   endfunction

   function automatic int owner_of(input int b, input int s);
      if (!taken(b, s)) return 0;
      return (b == 0) ? res0[s] : res1[s];
   endfunction

   task automatic model_clear();
      res0.delete();
      res1.delete();
      for (int i = 0; i < REQ_CNT; i++) age_m[i] = 0;
   endtask

   task automatic model_expect();
      bit elig [REQ_CNT];
      logic [REQ_CNT-1:0] g;
      logic [MAX_LAT-1:0] busy;
      int l, b, w;
      g = '0;
      for (int i = 0; i < REQ_CNT; i++) begin
         l = int'(bus.req_lat_i[i]);
         b = int'(bus.req_bank_i[i]);
         elig[i] = bus.req_valid_i[i] && !bus.flush_i && (l >= 1) && (l <= MAX_LAT) &&
                   !((l == 1) && bus.ext_block_i[b]) && !taken(b, cyc + l);
      end
      for (int bb = 0; bb < 2; bb++) begin
         for (int ll = 1; ll <= MAX_LAT; ll++) begin
            w = -1;
            for (int i = 0; i < REQ_CNT; i++)
               if (w < 0 && elig[i] && int'(bus.req_bank_i[i]) == bb &&
                   int'(bus.req_lat_i[i]) == ll && age_m[i] == STARVE_TH) w = i;
            for (int i = 0; i < REQ_CNT; i++)
               if (w < 0 && elig[i] && int'(bus.req_bank_i[i]) == bb &&
                   int'(bus.req_lat_i[i]) == ll) w = i;
            if (w >= 0) g[w] = 1'b1;
         end
      end
      exp_grant = g;
      check_eq("grant", 32'(bus.req_grant_o), 32'(g));
      for (int bb = 0; bb < 2; bb++) begin
         busy = '0;
         for (int k = 0; k < MAX_LAT; k++) busy[k] = taken(bb, cyc + k);
         check_eq("busy_map", 32'(bus.busy_map_o[bb]), 32'(busy));
         check_eq("slot_valid", 32'(bus.slot_valid_o[bb]), 32'(taken(bb, cyc)));
         check_eq("slot_owner", 32'(bus.slot_owner_o[bb]), 32'(owner_of(bb, cyc)));
      end
   endtask

   task automatic model_update();
      if (bus.flush_i) begin
         res0.delete();
         res1.delete();
      end else begin
         for (int i = 0; i < REQ_CNT; i++) begin
            if (exp_grant[i]) begin
               if (bus.req_bank_i[i] == 1'b0) res0[cyc + int'(bus.req_lat_i[i])] = i;
               else res1[cyc + int'(bus.req_lat_i[i])] = i;
            end
         end
      end
      for (int i = 0; i < REQ_CNT; i++) begin
         if (bus.flush_i || !bus.req_valid_i[i] || exp_grant[i]) age_m[i] = 0;
         else if (age_m[i] < STARVE_TH) age_m[i]++;
      end
      cyc++;
   endtask

   task automatic run_cycle();
      @(negedge clk);
      model_expect();
      obs_grant = bus.req_grant_o;
      obs_busy  = bus.busy_map_o;
      obs_valid = bus.slot_valid_o;
      obs_owner = bus.slot_owner_o;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush_i     = 1'b0;
      bus.req_valid_i = '0;
      bus.req_lat_i   = '0;
      bus.req_bank_i  = '0;
      bus.ext_block_i = '0;
   endtask

   task automatic set_req(input int i, input int l, input int b);
      bus.req_valid_i[i] = 1'b1;
      bus.req_lat_i[i]   = LW'(l);
      bus.req_bank_i[i]  = b[0];
   endtask

   task automatic idle_cycles(input int n);
      idle_inputs();
      for (int c = 0; c < n; c++) run_cycle();
   endtask

   logic [REQ_CNT-1:0] prev_valid;

   initial begin
      idle_inputs();
      model_clear();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset state.
      run_cycle();
      check_eq("rst_grant", 32'(obs_grant), 32'h0);
      check_eq("rst_busy", 32'(obs_busy), 32'h0);
      check_eq("rst_valid", 32'(obs_valid), 32'h0);
      check_eq("rst_owner", 32'(obs_owner), 32'h0);

      // Single L=3 reservation in bank 0.
      set_req(0, 3, 0);
      run_cycle();
      check_eq("t2_grant", 32'(obs_grant), 32'h1);
      idle_inputs();
      run_cycle();
      check_eq("t2_busy0", 32'(obs_busy[0]), 32'b0100);
      check_eq("t2_valid_early", 32'(obs_valid[0]), 32'h0);
      run_cycle();
      check_eq("t2_valid_early2", 32'(obs_valid[0]), 32'h0);
      run_cycle();
      check_eq("t2_valid", 32'(obs_valid[0]), 32'h1);
      check_eq("t2_owner", 32'(obs_owner[0]), 32'h0);
      run_cycle();
      check_eq("t2_valid_late", 32'(obs_valid[0]), 32'h0);
      idle_cycles(MAX_LAT);

      // Same (bank,L) contention, then a collision and a retarget by the loser.
      set_req(0, 2, 1);
      set_req(2, 2, 1);
      run_cycle();
      check_eq("t3_grant", 32'(obs_grant), 32'h1);
      bus.req_valid_i[0] = 1'b0;
      set_req(2, 1, 1);
      run_cycle();
      check_eq("t3_collide", 32'(obs_grant), 32'h0);
      set_req(2, 3, 1);
      run_cycle();
      check_eq("t3_retarget", 32'(obs_grant), 32'h4);
      idle_cycles(MAX_LAT + 1);

      // Starvation boost.
      for (int c = 0; c < 10; c++) begin
         set_req(0, 4, 0);
         set_req(1, 4, 0);
         run_cycle();
         check_eq("t4_grant", 32'(obs_grant), (c == 8) ? 32'h2 : 32'h1);
      end
      idle_cycles(MAX_LAT + 1);

      // Flush wipes reservations and suppresses same-cycle grants.
      set_req(0, 2, 0);
      set_req(1, 3, 0);
      set_req(2, 4, 0);
      run_cycle();
      check_eq("t5_grant", 32'(obs_grant), 32'h7);
      idle_inputs();
      bus.flush_i = 1'b1;
      set_req(0, 4, 0);
      run_cycle();
      check_eq("t5_flush_grant", 32'(obs_grant), 32'h0);
      check_eq("t5_busy_pre", 32'(obs_busy[0]), 32'b1110);
      idle_inputs();
      for (int c = 0; c < 3; c++) begin
         run_cycle();
         check_eq("t5_busy", 32'(obs_busy), 32'h0);
         check_eq("t5_valid", 32'(obs_valid), 32'h0);
      end

      // External block on bank 0 at L=1.
      bus.ext_block_i = 2'b01;
      set_req(0, 1, 0);
      set_req(1, 1, 1);
      run_cycle();
      check_eq("t6_grant", 32'(obs_grant), 32'h2);
      idle_inputs();
      run_cycle();
      check_eq("t6_valid", 32'(obs_valid), 32'b10);
      check_eq("t6_owner1", 32'(obs_owner[1]), 32'h1);
      idle_cycles(MAX_LAT);

      // Asynchronous reset mid-run clears the table without a clock edge.
      set_req(0, 4, 0);
      set_req(1, 3, 1);
      run_cycle();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      check_eq("t1_busy", 32'(bus.busy_map_o), 32'h0);
      check_eq("t1_valid", 32'(bus.slot_valid_o), 32'h0);
      model_clear();
      #1;
      rst_n = 1'b1;
      run_cycle();

      // Randomized traffic; waiting requesters mostly hold valid until granted.
      prev_valid = '0;
      for (int c = 0; c < 600; c++) begin
         bus.flush_i     = ($urandom_range(0, 31) == 0);
         bus.ext_block_i = 2'($urandom_range(0, 3));
         for (int i = 0; i < REQ_CNT; i++) begin
            if (prev_valid[i] && !obs_grant[i] && ($urandom_range(0, 7) != 0)) begin
               if ($urandom_range(0, 7) == 0) bus.req_lat_i[i] = LW'($urandom_range(1, MAX_LAT));
            end else begin
               bus.req_valid_i[i] = ($urandom_range(0, 1) == 1);
               bus.req_bank_i[i]  = ($urandom_range(0, 3) == 0);
               if ($urandom_range(0, 15) == 0) bus.req_lat_i[i] = LW'($urandom_range(0, 7));
               else if ($urandom_range(0, 1) == 0) bus.req_lat_i[i] = LW'(MAX_LAT);
               else bus.req_lat_i[i] = LW'($urandom_range(1, MAX_LAT));
            end
         end
         prev_valid = bus.req_valid_i;
         run_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
